teclado_scanner: RTL and testbench
==================================

# teclado_scanner

Parametrised matrix-keypad scanner and BCD entry register, the successor to the fixed 3-column keypad block. It drives one active-low column at a time and reads the active-low rows. Each press is debounced and must be released before the next one counts. Digits are shifted into a DIGITS-wide BCD entry register, and ENTER, CLEAR and BACKSPACE actions are supported. It sits between the board keypad pins and the display/consumer logic, which reads `entry` continuously and `value` on `value_valid`.

## Interface
- `COLS`, 3: number of driven columns; legal values 3 or 4.
- `ROWS`, 4: number of sensed rows; fixed at 4.
- `DIGITS`, 4: BCD digits in the entry register; legal range 1..8.
- `SETTLE_CYCLES`, 2: cycles a column is driven before its rows are sampled; at least 1.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a press or a release; at least 1.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in` in ROWS: row inputs, active-low; 4'b1111 means no key.
- `out` out COLS: column drive, active-low, exactly one bit low. Resets to column 0 low.
- `entry` out 4*DIGITS: live BCD entry, most significant digit in the top nibble. Resets to 0.
- `digit_count` out 4: number of digits entered, saturating at DIGITS. Resets to 0.
- `value` out 4*DIGITS: entry captured on ENTER. Resets to 0.
- `value_valid` out 1: one-cycle pulse when `value` updates. Resets to 0.
- `key_code` out 4: last accepted key, encoded `col*ROWS + row`. Resets to 0.
- `key_valid` out 1: one-cycle pulse per accepted press. Resets to 0.

## Operation
Key map, fixed in the package, listed as rows 0..3 for each column:
- col0: 1, 4, 7, CLEAR (`*`)
- col1: 2, 5, 8, 0
- col2: 3, 6, 9, ENTER (`#`)
- col3 (only when COLS=4): BACKSPACE, then three ignored keys

FSM states:
- SCAN: drive column `c`. After SETTLE_CYCLES cycles, sample `in`. If any row is low, latch `c` and the sampled pattern, set the counter to 1, and go to DEBOUNCE. Otherwise advance `c` (COLS-1 wraps to 0) and stay in SCAN.
- DEBOUNCE: each cycle `in` equals the latched pattern, increment the counter. Any mismatch returns to SCAN on the same column with no action. When the counter reaches DEBOUNCE_CYCLES, go to ACCEPT.
- ACCEPT: lasts one cycle. Pulse `key_valid`, update `key_code`, apply the action, go to RELEASE.
- RELEASE: keep the column driven. Count consecutive cycles with `in`=4'b1111; any low bit restarts the count. When the count reaches DEBOUNCE_CYCLES, advance the column and return to SCAN.

Row selection:
- If several rows are low, the lowest-index low row is the key.
- A pattern change during DEBOUNCE counts as a mismatch.

Actions:
- Digit: `entry <= {entry[4*DIGITS-5:0], d}`. The top digit is dropped when full. `digit_count` increments and saturates at DIGITS.
- BACKSPACE: `entry <= {4'h0, entry[4*DIGITS-1:4]}`. `digit_count` decrements, floored at 0.
- CLEAR: `entry` and `digit_count` go to 0. No `value_valid`.
- ENTER with `digit_count` > 0:
  - `value <= entry` and pulse `value_valid`.
  - In the same edge, `entry` and `digit_count` go to 0.
- ENTER with `digit_count` = 0: `key_valid` pulses only. `value` is unchanged and there is no `value_valid`.
- Ignored key: `key_valid` pulses, and no other output changes.

Arithmetic and width rules:
- The debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`; the counter never wraps.
- Entry digits are always in 0..9; no non-BCD nibble is ever written.

Reset:
- Asserting `rst_n` low at any point forces every output to its reset value, the state to SCAN and the column to 0.
- No pending press survives reset.

## Timing
Latencies:
- A column change on `out` is registered, so `in` is first sampled SETTLE_CYCLES cycles after `out` changes.
- With the first low sample at edge t, `key_valid`, `entry` and `value_valid` are high or updated in the cycle after edge t+DEBOUNCE_CYCLES.
- A held key produces exactly one `key_valid`.
- A new press is possible no earlier than DEBOUNCE_CYCLES clean-release cycles after the previous acceptance, plus a full scan return.
- An idle scan period is COLS*SETTLE_CYCLES cycles.

Boundary conditions:
- A glitch shorter than DEBOUNCE_CYCLES produces no `key_valid`.
- Bounce during RELEASE extends RELEASE and never re-accepts the key.
- `value_valid` and `key_valid` assert in the same cycle for an ENTER that captures a value.

## Structure
- Package `teclado_pkg` holds:
  - the state enum {SCAN, DEBOUNCE, ACCEPT, RELEASE};
  - the key-class enum {K_DIGIT, K_ENTER, K_CLEAR, K_BACK, K_NONE};
  - the function `key_map(col,row)` returning the class and digit.
- Sub-module `teclado_debounce`:
  - inputs: a pattern and a reference pattern, plus `clear`, `clk` and `rst_n`;
  - output: `stable`, asserted after DEBOUNCE_CYCLES matching cycles;
  - it is used for both press (reference = latched pattern) and release (reference = 4'b1111).

## Test plan
Benches use SETTLE_CYCLES=2 and DEBOUNCE_CYCLES=4.
- Press 1, 2, 3, 4, each held 10 cycles and released cleanly → `entry`=16'h1234, `digit_count`=4, four `key_valid` pulses.
- Press 5 after 1234 → `entry`=16'h2345; then press ENTER → `value`=16'h2345, one `value_valid` pulse, `entry`=0.
- Row-0 low for 3 cycles, then high → no `key_valid`, and scanning continues.
- Hold 7 for 50 cycles with 2-cycle bounces on release → exactly one `key_valid`, `entry`=16'h0007.
- Enter 9, 8, then BACKSPACE (COLS=4) → `entry`=16'h0009, `digit_count`=1; then CLEAR → `entry`=0, no `value_valid`.
- Assert `rst_n` low during DEBOUNCE after entering 12 → all outputs at reset values, `out`=~(1<<0); the released key gives no `key_valid`.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared types and the fixed keypad map for the teclado matrix scanner.
package teclado_pkg;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, ACCEPT, RELEASE} state_t;
    typedef enum logic [2:0] {K_DIGIT, K_ENTER, K_CLEAR, K_BACK, K_NONE} key_class_t;

    typedef struct packed {
        key_class_t kclass;
        logic [3:0] digit;
    } key_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    function automatic key_t key_map(input logic [1:0] col, input logic [1:0] row);
        key_t k;
        k.kclass = K_NONE;
        k.digit  = 4'd0;
        if (col == 2'd3) begin
            if (row == 2'd0) k.kclass = K_BACK;
        end else if (row == 2'd3) begin
            case (col)
                2'd0:    k.kclass = K_CLEAR;
                2'd1:    k.kclass = K_DIGIT;
                default: k.kclass = K_ENTER;
            endcase
        end else begin
            k.kclass = K_DIGIT;
            k.digit  = 4'd3 * {2'b00, row} + {2'b00, col} + 4'd1;
        end
        return k;
    endfunction

    // Several rows low at once: the lowest-index row is taken as the key.
    function automatic logic [1:0] first_low(input logic [3:0] pattern);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (!pattern[i]) r = 2'(i);
        return r;
    endfunction

endpackage

// File: rtl/teclado_debounce.sv
// Counts consecutive cycles where pattern equals reference; stable once the run reaches DEBOUNCE_CYCLES.
module teclado_debounce #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] reference,
    input  logic             clear,
    output logic             stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          match;

    always_comb begin
        match = (pattern == reference);
        cnt_d = cnt_q;
        if (clear || !match)
            cnt_d = '0;
        else if (cnt_q != TC)
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign stable = (cnt_q == TC);

endmodule

// File: rtl/teclado_scanner.sv
// Matrix keypad scanner feeding a BCD entry register with ENTER, CLEAR and BACKSPACE.
//   state    | meaning
//   SCAN     | drive one column, sample rows after settling, rotate columns when idle
//   DEBOUNCE | latched row pattern must hold for DEBOUNCE_CYCLES
//   ACCEPT   | one-cycle key_valid pulse; key action already applied
//   RELEASE  | wait for DEBOUNCE_CYCLES clean idle cycles before scanning again
module teclado_scanner
    import teclado_pkg::*;
#(
    parameter int COLS            = 3,
    parameter int ROWS            = 4,
    parameter int DIGITS          = 4,
    parameter int SETTLE_CYCLES   = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ROWS-1:0]     in,
    output logic [COLS-1:0]     out,
    output logic [4*DIGITS-1:0] entry,
    output logic [3:0]          digit_count,
    output logic [4*DIGITS-1:0] value,
    output logic                value_valid,
    output logic [3:0]          key_code,
    output logic                key_valid
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    COL_LAST    = 2'(COLS - 1);
    localparam logic [3:0]    DIGITS_MAX  = 4'(DIGITS);

    state_t              state_q, state_d;
    logic [1:0]          col_q, col_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [ROWS-1:0]     pat_q, pat_d;
    logic [4*DIGITS-1:0] entry_q, entry_d, value_q, value_d;
    logic [3:0]          count_q, count_d, key_code_q, key_code_d;
    logic                value_valid_q, value_valid_d, key_valid_q, key_valid_d;

    logic            sample, any_low, stable, db_clear, accept;
    logic [ROWS-1:0] db_ref;
    logic [1:0]      col_next, row_sel;
    key_t            key;

    teclado_debounce #(
        .WIDTH           (ROWS),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .pattern   (in),
        .reference (db_ref),
        .clear     (db_clear),
        .stable    (stable)
    );

    assign any_low = ~&in;
    assign sample  = (state_q == SCAN) && (settle_q == '0);
    assign accept  = (state_q == DEBOUNCE) && stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            col_q         <= '0;
            settle_q      <= SETTLE_LOAD;
            pat_q         <= '1;
            entry_q       <= '0;
            count_q       <= '0;
            value_q       <= '0;
            value_valid_q <= 1'b0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            settle_q      <= settle_d;
            pat_q         <= pat_d;
            entry_q       <= entry_d;
            count_q       <= count_d;
            value_q       <= value_d;
            value_valid_q <= value_valid_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN:     if (sample && any_low) state_d = DEBOUNCE;
            DEBOUNCE: begin
                if (stable)            state_d = ACCEPT;
                else if (in != pat_q)  state_d = SCAN;
            end
            ACCEPT:   state_d = RELEASE;
            RELEASE:  if (stable) state_d = SCAN;
            default:  state_d = SCAN;
        endcase
    end

    always_comb begin
        col_next      = (col_q == COL_LAST) ? 2'd0 : col_q + 2'd1;
        row_sel       = first_low(pat_q);
        key           = key_map(col_q, row_sel);
        col_d         = col_q;
        settle_d      = settle_q;
        pat_d         = pat_q;
        db_ref        = ROWS_IDLE;
        db_clear      = 1'b0;
        entry_d       = entry_q;
        count_d       = count_q;
        value_d       = value_q;
        key_code_d    = key_code_q;
        value_valid_d = 1'b0;
        key_valid_d   = 1'b0;

        // The run counter starts at 1 on the sampling edge, so SCAN compares `in` with itself.
        case (state_q)
            SCAN: begin
                db_ref   = in;
                db_clear = !(sample && any_low);
                if (!sample)
                    settle_d = settle_q - SW'(1);
                else if (any_low)
                    pat_d = in;
                else begin
                    col_d    = col_next;
                    settle_d = SETTLE_LOAD;
                end
            end
            DEBOUNCE: begin
                db_ref   = pat_q;
                db_clear = stable;
                if (!stable && in != pat_q) settle_d = SETTLE_LOAD;
            end
            ACCEPT:   db_clear = 1'b1;
            RELEASE: begin
                db_clear = stable;
                if (stable) begin
                    col_d    = col_next;
                    settle_d = SETTLE_LOAD;
                end
            end
            default: ;
        endcase

        if (accept) begin
            key_valid_d = 1'b1;
            key_code_d  = {col_q, row_sel};
            case (key.kclass)
                K_DIGIT: begin
                    entry_d = (entry_q << 4) | (4*DIGITS)'(key.digit);
                    if (count_q != DIGITS_MAX) count_d = count_q + 4'd1;
                end
                K_BACK: begin
                    entry_d = entry_q >> 4;
                    if (count_q != 4'd0) count_d = count_q - 4'd1;
                end
                K_CLEAR: begin
                    entry_d = '0;
                    count_d = '0;
                end
                K_ENTER: begin
                    if (count_q != 4'd0) begin
                        value_d       = entry_q;
                        value_valid_d = 1'b1;
                        entry_d       = '0;
                        count_d       = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out         = ~(COLS'(1) << col_q);
    assign entry       = entry_q;
    assign digit_count = count_q;
    assign value       = value_q;
    assign value_valid = value_valid_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_teclado_scanner.sv
// Directed bench for teclado_scanner: a decimal-arithmetic keypad model checked every cycle, plus literal pins.
module tb_teclado_scanner;
    localparam int COLS = 4;
    localparam int ROWS = 4;
    localparam int DIGITS = 4;
    localparam int S = 2;
    localparam int D = 4;
    localparam int MOD = 10000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  in_w;
    logic [3:0]  out_w;
    logic [15:0] entry, value;
    logic [3:0]  digit_count, key_code;
    logic        value_valid, key_valid;

    logic       key_down = 1'b0;
    int         key_col = 0;
    int         key_row = 0;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_val = 4'hF;

    int total = 0;
    int bad = 0;
    int kv_total = 0;
    int vv_total = 0;
    int q[$];
    int m_num = 0;
    int m_cnt = 0;
    int m_value = 0;

    teclado_scanner #(
        .COLS(COLS), .ROWS(ROWS), .DIGITS(DIGITS),
        .SETTLE_CYCLES(S), .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in(in_w), .out(out_w),
        .entry(entry), .digit_count(digit_count), .value(value),
        .value_valid(value_valid), .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // Keypad matrix: a held key pulls its row low only while its column is driven.
    always_comb begin
        in_w = 4'hF;
        if (ovr_en) in_w = ovr_val;
        else if (key_down && out_w[key_col] == 1'b0) in_w[key_row] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // 0..9 digit, 10 CLEAR, 11 ENTER, 12 BACKSPACE, 15 ignored
    function automatic int key_fn(input int code);
        case (code)
            0: return 1;   1: return 4;   2: return 7;   3: return 10;
            4: return 2;   5: return 5;   6: return 8;   7: return 0;
            8: return 3;   9: return 6;  10: return 9;  11: return 11;
            12: return 12;
            default: return 15;
        endcase
    endfunction

    function automatic int to_bcd(input int n);
        int r = 0;
        int v = n;
        for (int i = 0; i < DIGITS; i++) begin
            r = r | ((v % 10) << (4 * i));
            v = v / 10;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        int  c;
        int  f;
        bit  evv;
        if (!rst_n) begin
            q.delete();
            m_num = 0; m_cnt = 0; m_value = 0;
            chk("rst_out", int'(out_w), 14);
            chk("rst_entry", int'(entry), 0);
            chk("rst_count", int'(digit_count), 0);
            chk("rst_value", int'(value), 0);
            chk("rst_value_valid", int'(value_valid), 0);
            chk("rst_key_code", int'(key_code), 0);
            chk("rst_key_valid", int'(key_valid), 0);
        end else begin
            evv = 1'b0;
            if (key_valid) begin
                kv_total++;
                chk("key_expected", int'(q.size() > 0), 1);
                if (q.size() > 0) begin
                    c = q.pop_front();
                    chk("key_code", int'(key_code), c);
                    f = key_fn(c);
                    if (f <= 9) begin
                        m_num = (m_num * 10 + f) % MOD;
                        if (m_cnt < DIGITS) m_cnt++;
                    end else if (f == 10) begin
                        m_num = 0; m_cnt = 0;
                    end else if (f == 11) begin
                        if (m_cnt > 0) begin
                            m_value = m_num; m_num = 0; m_cnt = 0; evv = 1'b1;
                        end
                    end else if (f == 12) begin
                        m_num = m_num / 10;
                        if (m_cnt > 0) m_cnt--;
                    end
                end
            end
            if (value_valid) vv_total++;
            chk("entry", int'(entry), to_bcd(m_num));
            chk("digit_count", int'(digit_count), m_cnt);
            chk("value", int'(value), to_bcd(m_value));
            chk("value_valid", int'(value_valid), int'(evv));
            chk("out_onehot", $countones(~out_w), 1);
        end
    end

    task automatic press(input int col, input int row, input int hold, input bit bouncy);
        int n = 0;
        bit seen = 1'b0;
        q.push_back(col * ROWS + row);
        key_col = col; key_row = row; key_down = 1'b1;
        while ((!seen || n < hold) && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (key_valid) seen = 1'b1;
        end
        chk("press_seen", int'(seen), 1);
        if (bouncy) begin
            for (int b = 0; b < 3; b++) begin
                key_down = 1'b0; repeat (2) @(posedge clk);
                key_down = 1'b1; repeat (2) @(posedge clk);
            end
        end
        key_down = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        int  kv_at;
        bit  found;
        bit  changed;
        logic [3:0] out0;

        #2 rst_n = 1'b0;
        key_col = 0; key_row = 0; key_down = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        q.push_back(0);
        kv_at = 0;
        for (int k = 1; k <= 20 && kv_at == 0; k++) begin
            @(posedge clk); #1;
            if (key_valid) kv_at = k;
        end
        chk("accept_latency", kv_at, S + D);
        repeat (6) @(posedge clk);
        key_down = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        press(1, 0, 10, 1'b0);
        press(2, 0, 10, 1'b0);
        press(0, 1, 10, 1'b0);
        chk("lit_entry_1234", int'(entry), 16'h1234);
        chk("lit_count_4", int'(digit_count), 4);
        chk("lit_kv_4", kv_total, 4);

        press(1, 1, 10, 1'b0);
        chk("lit_entry_2345", int'(entry), 16'h2345);
        press(2, 3, 10, 1'b0);
        chk("lit_value_2345", int'(value), 16'h2345);
        chk("lit_entry_after_enter", int'(entry), 0);
        chk("lit_vv_1", vv_total, 1);

        ovr_val = 4'b1110; ovr_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 ovr_en = 1'b0;
        out0 = out_w;
        changed = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_w != out0) changed = 1'b1;
        end
        chk("glitch_scan_continues", int'(changed), 1);
        chk("glitch_no_key", kv_total, 6);

        press(0, 2, 50, 1'b1);
        chk("lit_bounce_kv", kv_total, 7);
        chk("lit_entry_0007", int'(entry), 16'h0007);

        press(0, 3, 10, 1'b0);
        press(2, 2, 10, 1'b0);
        press(1, 2, 10, 1'b0);
        chk("lit_entry_0098", int'(entry), 16'h0098);
        press(3, 0, 10, 1'b0);
        chk("lit_entry_0009", int'(entry), 16'h0009);
        chk("lit_count_1", int'(digit_count), 1);
        press(0, 3, 10, 1'b0);
        chk("lit_clear_entry", int'(entry), 0);
        chk("lit_clear_no_vv", vv_total, 1);
        press(2, 3, 10, 1'b0);
        chk("lit_empty_enter_value", int'(value), 16'h2345);
        chk("lit_empty_enter_no_vv", vv_total, 1);
        press(3, 1, 10, 1'b0);
        chk("lit_ignored_code", int'(key_code), 13);
        chk("lit_ignored_entry", int'(entry), 0);

        press(0, 0, 10, 1'b0);
        press(1, 0, 10, 1'b0);
        chk("lit_entry_0012", int'(entry), 16'h0012);
        key_col = 2; key_row = 0; key_down = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk); #1;
            if (in_w != 4'hF) found = 1'b1;
        end
        chk("reach_column", int'(found), 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_out", int'(out_w), 4'b1110);
        chk("lit_rst_entry", int'(entry), 0);
        chk("lit_rst_count", int'(digit_count), 0);
        key_down = 1'b0;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("lit_no_key_after_rst", kv_total, 16);
        chk("lit_value_after_rst", int'(value), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

endmodule
